// File: rtl/reloj_control.sv
// 24-hour BCD clock with three-mode set FSM and a four-digit multiplexed display scanner.
// Time fields are kept in BCD so the display path needs no conversion.
module reloj_control #(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_btn_modo,
    input  logic       i_btn_inc,
    output logic [2:0] o_decenas_min,
    output logic [3:0] o_unidades_min,
    output logic [1:0] o_decenas_hr,
    output logic [3:0] o_unidades_hr,
    output logic [1:0] o_modo,
    output logic [3:0] o_digito,
    output logic [3:0] o_anodo,
    output logic       o_seg_tick
);

    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {
        StNormal = 2'b00,
        StSetHr  = 2'b01,
        StSetMin = 2'b10
    } modo_e;

    modo_e         r_state;
    logic [PW-1:0] r_pre;
    logic [SW-1:0] r_scan_cnt;
    logic [1:0]    r_idx;

    logic [2:0]    r_sec_dec;
    logic [3:0]    r_sec_uni;
    logic [2:0]    r_min_dec;
    logic [3:0]    r_min_uni;
    logic [1:0]    r_hr_dec;
    logic [3:0]    r_hr_uni;

    logic          w_pre_last;
    logic          w_scan_last;
    logic          w_tick;

    logic          w_sec_wrap;
    logic [2:0]    w_sec_dec_nx;
    logic [3:0]    w_sec_uni_nx;
    logic          w_min_wrap;
    logic [2:0]    w_min_dec_nx;
    logic [3:0]    w_min_uni_nx;
    logic          w_hr_wrap;
    logic [1:0]    w_hr_dec_nx;
    logic [3:0]    w_hr_uni_nx;

    assign w_pre_last  = (r_pre == PW'(TICK_DIV - 1));
    assign w_scan_last = (r_scan_cnt == SW'(SCAN_DIV - 1));
    assign w_tick      = (r_state == StNormal) && w_pre_last;

    // BCD successor of every time field, with the wrap flag that feeds the next field's carry.
    always_comb begin
        w_sec_wrap   = (r_sec_dec == 3'd5) && (r_sec_uni == 4'd9);
        w_sec_uni_nx = (r_sec_uni == 4'd9) ? 4'd0 : r_sec_uni + 4'd1;
        w_sec_dec_nx = r_sec_dec;
        if (r_sec_uni == 4'd9) begin
            w_sec_dec_nx = (r_sec_dec == 3'd5) ? 3'd0 : r_sec_dec + 3'd1;
        end

        w_min_wrap   = (r_min_dec == 3'd5) && (r_min_uni == 4'd9);
        w_min_uni_nx = (r_min_uni == 4'd9) ? 4'd0 : r_min_uni + 4'd1;
        w_min_dec_nx = r_min_dec;
        if (r_min_uni == 4'd9) begin
            w_min_dec_nx = (r_min_dec == 3'd5) ? 3'd0 : r_min_dec + 3'd1;
        end

        w_hr_wrap   = (r_hr_dec == 2'd2) && (r_hr_uni == 4'd3);
        w_hr_dec_nx = r_hr_dec;
        w_hr_uni_nx = r_hr_uni + 4'd1;
        if (w_hr_wrap) begin
            w_hr_dec_nx = 2'd0;
            w_hr_uni_nx = 4'd0;
        end else if (r_hr_uni == 4'd9) begin
            w_hr_dec_nx = r_hr_dec + 2'd1;
            w_hr_uni_nx = 4'd0;
        end
    end

    // Mode FSM and timekeeping. A mode change always wins over btn_inc and over a pending tick.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= StNormal;
            r_pre     <= '0;
            r_sec_dec <= 3'd0;
            r_sec_uni <= 4'd0;
            r_min_dec <= 3'd0;
            r_min_uni <= 4'd0;
            r_hr_dec  <= 2'd0;
            r_hr_uni  <= 4'd0;
        end else begin
            case (r_state)
                StNormal: begin
                    if (i_btn_modo) begin
                        r_state   <= StSetHr;
                        r_pre     <= '0;
                        r_sec_dec <= 3'd0;
                        r_sec_uni <= 4'd0;
                    end else if (w_pre_last) begin
                        r_pre     <= '0;
                        r_sec_dec <= w_sec_dec_nx;
                        r_sec_uni <= w_sec_uni_nx;
                        if (w_sec_wrap) begin
                            r_min_dec <= w_min_dec_nx;
                            r_min_uni <= w_min_uni_nx;
                            if (w_min_wrap) begin
                                r_hr_dec <= w_hr_dec_nx;
                                r_hr_uni <= w_hr_uni_nx;
                            end
                        end
                    end else begin
                        r_pre <= r_pre + 1'b1;
                    end
                end
                StSetHr: begin
                    r_pre     <= '0;
                    r_sec_dec <= 3'd0;
                    r_sec_uni <= 4'd0;
                    if (i_btn_modo) begin
                        r_state <= StSetMin;
                    end else if (i_btn_inc) begin
                        r_hr_dec <= w_hr_dec_nx;
                        r_hr_uni <= w_hr_uni_nx;
                    end
                end
                StSetMin: begin
                    r_pre     <= '0;
                    r_sec_dec <= 3'd0;
                    r_sec_uni <= 4'd0;
                    if (i_btn_modo) begin
                        r_state <= StNormal;
                    end else if (i_btn_inc) begin
                        r_min_dec <= w_min_dec_nx;
                        r_min_uni <= w_min_uni_nx;
                    end
                end
                default: begin
                    r_state <= StNormal;
                    r_pre   <= '0;
                end
            endcase
        end
    end

    // Display scan runs in every mode, independent of timekeeping.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_scan_cnt <= '0;
            r_idx      <= 2'd0;
        end else if (w_scan_last) begin
            r_scan_cnt <= '0;
            r_idx      <= r_idx + 2'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    always_comb begin
        o_digito = 4'd0;
        o_anodo  = 4'b1110;
        unique case (r_idx)
            2'd0: begin
                o_digito = r_min_uni;
                o_anodo  = 4'b1110;
            end
            2'd1: begin
                o_digito = {1'b0, r_min_dec};
                o_anodo  = 4'b1101;
            end
            2'd2: begin
                o_digito = r_hr_uni;
                o_anodo  = 4'b1011;
            end
            2'd3: begin
                o_digito = {2'b00, r_hr_dec};
                o_anodo  = 4'b0111;
            end
            default: begin
                o_digito = 4'd0;
                o_anodo  = 4'b1110;
            end
        endcase
    end

    assign o_decenas_min  = r_min_dec;
    assign o_unidades_min = r_min_uni;
    assign o_decenas_hr   = r_hr_dec;
    assign o_unidades_hr  = r_hr_uni;
    assign o_modo         = r_state;
    assign o_seg_tick     = w_tick;

    a_anodo_onehot: assert property (@(posedge i_clk) disable iff (i_reset)
        $onehot(~o_anodo));
    a_modo_legal: assert property (@(posedge i_clk) disable iff (i_reset)
        o_modo != 2'b11);
    a_hr_range: assert property (@(posedge i_clk) disable iff (i_reset)
        (r_hr_uni <= 4'd9) && ((r_hr_dec < 2'd2) || (r_hr_uni <= 4'd3)));
    a_min_range: assert property (@(posedge i_clk) disable iff (i_reset)
        (r_min_dec <= 3'd5) && (r_min_uni <= 4'd9));

endmodule

// File: tb/tb_reloj_control.sv
// Randomised bench for reloj_control: a seconds-of-day reference model feeds a queue that a
// negedge monitor drains against the DUT outputs, plus directed scenario checks.
module tb_reloj_control;

    localparam int unsigned TD = 4;
    localparam int unsigned SD = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_modo = 1'b0;
    logic       btn_inc = 1'b0;
    logic [2:0] dec_min;
    logic [3:0] uni_min;
    logic [1:0] dec_hr;
    logic [3:0] uni_hr;
    logic [1:0] modo;
    logic [3:0] digito;
    logic [3:0] anodo;
    logic       seg_tick;

    reloj_control #(
        .TICK_DIV(TD),
        .SCAN_DIV(SD)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_btn_modo    (btn_modo),
        .i_btn_inc     (btn_inc),
        .o_decenas_min (dec_min),
        .o_unidades_min(uni_min),
        .o_decenas_hr  (dec_hr),
        .o_unidades_hr (uni_hr),
        .o_modo        (modo),
        .o_digito      (digito),
        .o_anodo       (anodo),
        .o_seg_tick    (seg_tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int tick_cnt = 0;

    // Reference model: whole time of day as a seconds count, mode as 0/1/2.
    int m_secs, m_mode, m_pre, m_scan, m_idx;
    logic [23:0] exp_q[$];

    logic [3:0] an_tbl[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [3:0] dg_tbl[4] = '{4'd4, 4'd3, 4'd2, 4'd1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] model_vec();
        int h, mi;
        logic [3:0] dg[4];
        logic [3:0] an;
        logic tk;
        h  = m_secs / 3600;
        mi = (m_secs / 60) % 60;
        dg[0] = 4'(mi % 10);
        dg[1] = 4'(mi / 10);
        dg[2] = 4'(h % 10);
        dg[3] = 4'(h / 10);
        an = 4'b1111 ^ (4'b0001 << m_idx);
        tk = (m_mode == 0) && (m_pre == int'(TD) - 1);
        return {2'(m_mode), 2'(h / 10), 4'(h % 10), 3'(mi / 10), 4'(mi % 10), dg[m_idx], an, tk};
    endfunction

    task automatic model_step(input logic bm, input logic bi);
        int h, mi;
        h  = m_secs / 3600;
        mi = (m_secs / 60) % 60;
        if (m_scan == int'(SD) - 1) begin
            m_scan = 0;
            m_idx  = (m_idx + 1) % 4;
        end else begin
            m_scan++;
        end
        if (bm) begin
            m_secs = h * 3600 + mi * 60;
            m_pre  = 0;
            m_mode = (m_mode + 1) % 3;
        end else if (m_mode == 0) begin
            if (m_pre == int'(TD) - 1) begin
                m_pre  = 0;
                m_secs = (m_secs + 1) % 86400;
            end else begin
                m_pre++;
            end
        end else if (bi) begin
            if (m_mode == 1) m_secs = ((h + 1) % 24) * 3600 + mi * 60;
            else             m_secs = h * 3600 + ((mi + 1) % 60) * 60;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_secs = 0; m_mode = 0; m_pre = 0; m_scan = 0; m_idx = 0;
                exp_q.delete();
            end else begin
                model_step(btn_modo, btn_inc);
            end
            exp_q.push_back(model_vec());
        end
    end

    initial begin
        logic [23:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("scoreboard", {8'h0, modo, dec_hr, uni_hr, dec_min, uni_min, digito, anodo,
                                     seg_tick}, {8'h0, e});
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!reset && seg_tick) tick_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Called at posedge+1; holds the buttons across exactly one rising edge.
    task automatic cycle(input logic m, input logic i);
        btn_modo = m;
        btn_inc  = i;
        @(posedge clk);
        #1;
        btn_modo = 1'b0;
        btn_inc  = 1'b0;
    endtask

    task automatic check_time(input string name, input int h, input int mi);
        check({name, "_hr"}, {26'h0, dec_hr, uni_hr}, {26'h0, 2'(h / 10), 4'(h % 10)});
        check({name, "_min"}, {25'h0, dec_min, uni_min}, {25'h0, 3'(mi / 10), 4'(mi % 10)});
    endtask

    initial begin
        int t0, n, k;
        logic [3:0] prev;
        logic found;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_modo", 32'(modo), 32'd0);
        check("rst_anodo", 32'(anodo), 32'hE);
        check("rst_digito", 32'(digito), 32'd0);
        check("rst_tick", 32'(seg_tick), 32'd0);
        check_time("rst", 0, 0);
        reset = 1'b0;

        // 240 cycles of NORMAL give 60 ticks and one minute.
        t0 = tick_cnt;
        repeat (240) @(posedge clk);
        #1;
        check("ticks_240", 32'(tick_cnt - t0), 32'd60);
        check_time("after_240", 0, 1);

        // Set 23:59, run 60 ticks, expect midnight right after the last one.
        cycle(1'b1, 1'b0);
        repeat (23) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0);
        repeat (58) cycle(1'b0, 1'b1);
        check_time("set_2359", 23, 59);
        cycle(1'b1, 1'b0);
        check("back_normal", 32'(modo), 32'd0);
        n = 0;
        k = 0;
        while (n < 60 && k < 400) begin
            if (seg_tick) n++;
            if (n < 60) cycle(1'b0, 1'b0);
            k++;
        end
        check("ticks_60_bound", 32'(n), 32'd60);
        check_time("at_tick60", 23, 59);
        cycle(1'b0, 1'b0);
        check_time("midnight", 0, 0);

        // 61 increments in SET_MIN from 00, no ticks meanwhile.
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        check("in_set_min", 32'(modo), 32'd2);
        t0 = tick_cnt;
        repeat (61) cycle(1'b0, 1'b1);
        check_time("min61", 0, 1);
        check("set_no_ticks", 32'(tick_cnt - t0), 32'd0);
        cycle(1'b1, 1'b0);

        // Simultaneous buttons in NORMAL: mode advances, increment dropped.
        cycle(1'b1, 1'b1);
        check("both_modo", 32'(modo), 32'd1);
        check_time("both_time", 0, 1);

        // 12:34 display scan, each digit held two cycles.
        repeat (12) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0);
        repeat (33) cycle(1'b0, 1'b1);
        check_time("set_1234", 12, 34);
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            prev = anodo;
            cycle(1'b0, 1'b0);
            if (prev == 4'b0111 && anodo == 4'b1110) found = 1'b1;
        end
        check("scan_sync", 32'(found), 32'd1);
        for (int i = 0; i < 16; i++) begin
            check("scan_anodo", 32'(anodo), 32'(an_tbl[(i / 2) % 4]));
            check("scan_digito", 32'(digito), 32'(dg_tbl[(i / 2) % 4]));
            cycle(1'b0, 1'b0);
        end

        // Reset mid-SET_HR with scan index 2 takes effect before the next edge.
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        k = 0;
        while (m_idx != 2 && k < 10) begin
            cycle(1'b0, 1'b0);
            k++;
        end
        check("idx2_reached", 32'(m_idx), 32'd2);
        check("pre_rst_modo", 32'(modo), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_modo", 32'(modo), 32'd0);
        check("mid_rst_anodo", 32'(anodo), 32'hE);
        check("mid_rst_digito", 32'(digito), 32'd0);
        check_time("mid_rst", 0, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // btn_modo coinciding with a tick, then prescaler restart on return to NORMAL.
        k = 0;
        while (!seg_tick && k < 20) begin
            cycle(1'b0, 1'b0);
            k++;
        end
        check("tick_seen", 32'(seg_tick), 32'd1);
        cycle(1'b1, 1'b0);
        check("tick_drop_modo", 32'(modo), 32'd1);
        check("tick_drop_tick", 32'(seg_tick), 32'd0);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        k = 0;
        while (!seg_tick && k < 20) begin
            cycle(1'b0, 1'b0);
            k++;
        end
        check("restart_latency", 32'(k), 32'(TD - 1));

        // Random phase: buttons and occasional asynchronous reset.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) reset = 1'b1;
            cycle(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) == 0));
            reset = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reloj_control.md
RELOJ_CONTROL -- requirements
Module: reloj_control

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clk cycles per one-second tick; legal range is 2 or more.
REQ-002 Parameter SCAN_DIV, default 50000, clk cycles per display digit slot; legal range is 2 or more.
REQ-003 clk  input  1  single system clock; all state SHALL change on its rising edge only.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 btn_modo  input  1  debounced single-cycle pulse; advances the mode.
REQ-006 btn_inc  input  1  debounced single-cycle pulse; increments the field selected in set mode.
REQ-007 decenas_min  output  3  BCD minutes tens, range 0-5.
REQ-008 unidades_min  output  4  BCD minutes units, range 0-9.
REQ-009 decenas_hr  output  2  BCD hours tens, range 0-2.
REQ-010 unidades_hr  output  4  BCD hours units, range 0-9; hours tens and units together SHALL never exceed 23.
REQ-011 modo  output  2  current state: 00 NORMAL, 01 SET_HR, 10 SET_MIN; code 11 SHALL never appear.
REQ-012 digito  output  4  BCD value of the digit currently scanned, zero-extended; feeds the 7-segment encoder.
REQ-013 anodo  output  4  one-hot, active-low digit enable.
REQ-014 seg_tick  output  1  one-cycle pulse on every counted second.

Function
REQ-015 FSM transitions SHALL occur only on btn_modo: NORMAL -> SET_HR -> SET_MIN -> NORMAL, one step per pulse.
REQ-016 NORMAL: the prescaler SHALL count 0..TICK_DIV-1 and wrap; seg_tick SHALL be 1 in the cycle the prescaler is at TICK_DIV-1.
REQ-017 NORMAL: on seg_tick, the internal seconds counter (0-59) SHALL increment, with registered results visible on the next cycle.
REQ-018 Seconds 59 plus a tick SHALL go to 0 and carry +1 into minutes; minutes 59 plus a carry SHALL go to 00 and carry +1 into hours.
REQ-019 Hours SHALL roll 09 -> 10, 19 -> 20 and 23 -> 00; a tick at 23:59:59 SHALL produce 00:00:00 in one cycle.
REQ-020 All time fields SHALL be stored and incremented as BCD; no binary-to-BCD conversion path is permitted.
REQ-021 SET_HR and SET_MIN: the prescaler and seconds SHALL be held at 0, and seg_tick SHALL stay 0.
REQ-022 SET_HR: btn_inc SHALL increment the hours with wrap 23 -> 00 and no carry into any other field.
REQ-023 SET_MIN: btn_inc SHALL increment the minutes with wrap 59 -> 00 and no carry into hours.
REQ-024 NORMAL: btn_inc SHALL be ignored.
REQ-025 btn_modo and btn_inc in the same cycle: the mode change SHALL take effect and btn_inc SHALL be discarded.
REQ-026 btn_modo in NORMAL in the same cycle as seg_tick: the tick SHALL be discarded, the state SHALL become SET_HR, and seconds and the prescaler SHALL clear to 0.
REQ-027 On the SET_MIN -> NORMAL transition, timekeeping SHALL restart with the prescaler at 0 and seconds at 0.
REQ-028 Scan: the scan counter SHALL count 0..SCAN_DIV-1 in every mode; at SCAN_DIV-1 the digit index (0-3) SHALL advance with wrap 3 -> 0.
REQ-029 Scan mapping: index 0 = unidades_min with anodo 1110; index 1 = decenas_min with 1101; index 2 = unidades_hr with 1011; index 3 = decenas_hr with 0111.
REQ-030 digito and anodo SHALL be a combinational function of the digit index and the current time registers, with zero added latency.
REQ-031 anodo SHALL always be exactly one-hot low, never 1111 and never more than one bit low.

Reset
REQ-032 Asserting reset SHALL immediately force the time to 00:00, seconds to 0, modo to 00, the prescaler, scan counter and digit index to 0, anodo to 1110, digito to 0 and seg_tick to 0.
REQ-033 Reset asserted during any mode, or mid-scan, SHALL override all inputs; btn_modo and btn_inc SHALL be ignored while reset is high.
REQ-034 After reset deasserts, the first prescaler increment and the first scan-counter increment SHALL occur on the first rising clk edge.

Verification (TICK_DIV=4, SCAN_DIV=2)
REQ-035 Reset, then run 240 clk cycles in NORMAL -> 60 seg_tick pulses, time reads 00:01 (decenas_min 0, unidades_min 1).
REQ-036 Set 23:59 through the set modes, return to NORMAL, then wait 60 ticks -> time reads 00:00 on the cycle after the 60th seg_tick.
REQ-037 In SET_MIN apply 61 btn_inc pulses from 00 -> minutes read 01, hours unchanged, seg_tick stays 0 throughout.
REQ-038 btn_modo and btn_inc in the same cycle in NORMAL -> modo reads 01, hours unchanged.
REQ-039 Time 12:34 -> anodo/digito cycle 1110/4, 1101/3, 1011/2, 0111/1, with each pair held 2 cycles, then repeat.
REQ-040 Assert reset mid-SET_HR with scan index 2 -> modo 00, time 00:00, anodo 1110, digito 0 in the same cycle.
